multicycle_cu: RTL and testbench

- Parametrised multi-cycle control unit; successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Drives the shared-memory multi-cycle datapath (IR, PC, ALU muxes, register file).
- Handshakes with a variable-latency unified memory.
- Adds addi, jump and illegal-opcode detection.

---
 rtl/multicycle_cu_if.sv | 47 ++++
 rtl/multicycle_cu.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cu_if.sv
// Control-unit bundle between the multicycle_cu FSM and the datapath/memory side.
// MULTICYCLE_CU_STALL_EN adds the stall input.
interface multicycle_cu_if #(
    parameter int unsigned OPW = 3
);
    logic [OPW-1:0] opcode;
    logic           mem_ready;
`ifdef MULTICYCLE_CU_STALL_EN
    logic           stall;
`endif
    logic           mem_read;
    logic           mem_write;
    logic           i_or_d;
    logic           ir_write;
    logic           pc_write;
    logic           pc_write_cond;
    logic [1:0]     pc_src;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic           ext_op;
    logic           reg_dest;
    logic           reg_write;
    logic           mem_to_reg;
    logic           instr_done;
    logic           illegal;

    modport master (
`ifdef MULTICYCLE_CU_STALL_EN
        input  stall,
`endif
        input  opcode, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_src, alu_src_a, alu_src_b, alu_op, ext_op, reg_dest,
               reg_write, mem_to_reg, instr_done, illegal
    );

    modport slave (
`ifdef MULTICYCLE_CU_STALL_EN
        output stall,
`endif
        output opcode, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_src, alu_src_a, alu_src_b, alu_op, ext_op, reg_dest,
               reg_write, mem_to_reg, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for a
// shared-memory datapath. MULTICYCLE_CU_STALL_EN adds a state-holding stall input.
module multicycle_cu #(
    parameter int unsigned OPW      = 3,
    parameter int unsigned OP_RTYPE = 0,
    parameter int unsigned OP_ADDI  = 1,
    parameter int unsigned OP_SW    = 2,
    parameter int unsigned OP_LW    = 4,
    parameter int unsigned OP_BEQ   = 6,
    parameter int unsigned OP_JMP   = 7
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_cu_if.master  cu
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       reg_dest;
        logic       reg_write;
        logic       mem_to_reg;
        logic       instr_done;
        logic       in_fetch;
        logic       in_decode;
        logic       in_memwr;
    } ctl_t;

    state_t state;
    state_t state_n;
    ctl_t   ctl_q;
    logic   rtype_q;
    logic   rtype_n;
    logic   lw_q;
    logic   lw_n;
    logic   stall_c;
    logic   take_c;
    logic   legal_c;
    logic   live_c;
    logic   run_c;

`ifdef MULTICYCLE_CU_STALL_EN
    assign stall_c = cu.stall;
`else
    assign stall_c = 1'b0;
`endif

    assign legal_c = (cu.opcode == OPW'(OP_RTYPE)) || (cu.opcode == OPW'(OP_ADDI)) ||
                     (cu.opcode == OPW'(OP_SW))    || (cu.opcode == OPW'(OP_LW))   ||
                     (cu.opcode == OPW'(OP_BEQ))   || (cu.opcode == OPW'(OP_JMP));

    // Successor state ignoring stall.
    function automatic state_t next_state(state_t s, logic [OPW-1:0] op, logic ready,
                                          logic lw);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OPW'(OP_LW) || op == OPW'(OP_SW)) n = S_MEMADR;
                else if (op == OPW'(OP_RTYPE))              n = S_EXEC_R;
                else if (op == OPW'(OP_ADDI))               n = S_EXEC_I;
                else if (op == OPW'(OP_BEQ))                n = S_BRANCH;
                else if (op == OPW'(OP_JMP))                n = S_JUMP;
                else                                        n = S_FETCH;
            end
            S_MEMADR: n = lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  n = ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  n = ready ? S_FETCH : S_MEMWR;
            S_EXEC_R: n = S_ALUWB;
            S_EXEC_I: n = S_ALUWB;
            default:  n = S_FETCH;
        endcase
        return n;
    endfunction

    // Moore control word of a state; rtype selects the ALUWB destination register.
    function automatic ctl_t decode(state_t s, logic rtype);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'd1;
                c.in_fetch  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'd2;
                c.ext_op    = 1'b1;
                c.in_decode = 1'b1;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                c.ext_op    = 1'b1;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
                c.in_memwr  = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'd2;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                c.ext_op    = 1'b1;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.reg_dest   = rtype;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'd1;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 2'd1;
                c.instr_done    = 1'b1;
            end
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_src     = 2'd2;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign state_n = stall_c ? state : next_state(state, cu.opcode, cu.mem_ready, lw_q);
    assign take_c  = (state == S_DECODE) && !stall_c;
    assign rtype_n = take_c ? (cu.opcode == OPW'(OP_RTYPE)) : rtype_q;
    assign lw_n    = take_c ? (cu.opcode == OPW'(OP_LW))    : lw_q;

    // State, held instruction type and the control word of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            rtype_q <= 1'b0;
            lw_q    <= 1'b0;
            ctl_q   <= decode(S_FETCH, 1'b0);
        end else begin
            state   <= state_n;
            rtype_q <= rtype_n;
            lw_q    <= lw_n;
            ctl_q   <= decode(state_n, rtype_n);
        end
    end

    // Everything is silenced during reset; stall additionally masks requests and enables.
    assign live_c = ~rst;
    assign run_c  = live_c & ~stall_c;

    assign cu.mem_read      = ctl_q.mem_read & run_c;
    assign cu.mem_write     = ctl_q.mem_write & run_c;
    assign cu.i_or_d        = ctl_q.i_or_d & live_c;
    assign cu.ir_write      = ctl_q.in_fetch & cu.mem_ready & run_c;
    assign cu.pc_write      = (ctl_q.pc_write | (ctl_q.in_fetch & cu.mem_ready)) & run_c;
    assign cu.pc_write_cond = ctl_q.pc_write_cond & run_c;
    assign cu.pc_src        = ctl_q.pc_src & {2{live_c}};
    assign cu.alu_src_a     = ctl_q.alu_src_a & live_c;
    assign cu.alu_src_b     = ctl_q.alu_src_b & {2{live_c}};
    assign cu.alu_op        = ctl_q.alu_op & {2{live_c}};
    assign cu.ext_op        = ctl_q.ext_op & live_c;
    assign cu.reg_dest      = ctl_q.reg_dest & live_c;
    assign cu.reg_write     = ctl_q.reg_write & run_c;
    assign cu.mem_to_reg    = ctl_q.mem_to_reg & live_c;
    assign cu.instr_done    = (ctl_q.instr_done | (ctl_q.in_memwr & cu.mem_ready)) & run_c;
    assign cu.illegal       = ctl_q.in_decode & ~legal_c & run_c;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu: random instruction stream with random memory
// wait states, checked per retired instruction against a latency/enable-count model.
module tb_multicycle_cu;
    localparam int unsigned OPW     = 3;
    localparam int          N_INSTR = 300;
    localparam int          OP_RTYPE = 0, OP_ADDI = 1, OP_SW = 2, OP_LW = 4,
                            OP_BEQ = 6, OP_JMP = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_cu_if #(.OPW(OPW)) bus();
    multicycle_cu #(.OPW(OPW)) dut (.clk(clk), .rst(rst), .cu(bus));

    typedef struct {
        int op;
        int cycles;
        int mr, mw, rw, pw, pcc, irw, done, ill;
        int rdst, m2r, last_src;
    } exp_t;

    exp_t expq[$];
    int   latq[$];
    int   opq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   retired = 0;
    bit   run_en = 1'b0;

    // Responder state
    bit dec_next = 1'b0, dec_now = 1'b0, st = 1'b0, in_access = 1'b0;
    int wait_left = 0, cur_op = 0;

    // Monitor accumulators for the instruction in flight
    int cyc = 0, nst = 0, a_mr = 0, a_mw = 0, a_rw = 0, a_pw = 0, a_pcc = 0, a_irw = 0;
    int a_done = 0, a_ill = 0, a_rdst = 0, a_m2r = 0, a_src = 0, a_pcc_src = 0, a_pcc_op = 0;

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [18:0] outs();
        return {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.ext_op, bus.reg_dest, bus.reg_write, bus.mem_to_reg, bus.instr_done,
                bus.illegal};
    endfunction

    // Per-instruction expectations straight from the instruction-class rules.
    function automatic exp_t model(int op, int fw, int dw);
        exp_t e;
        e = '{op: op, cycles: 0, mr: fw + 1, mw: 0, rw: 0, pw: 1, pcc: 0, irw: 1,
              done: 1, ill: 0, rdst: 0, m2r: 0, last_src: 0};
        case (op)
            OP_RTYPE: begin e.cycles = 4 + fw; e.rw = 1; e.rdst = 1; end
            OP_ADDI:  begin e.cycles = 4 + fw; e.rw = 1; end
            OP_LW:    begin e.cycles = 5 + fw + dw; e.rw = 1; e.m2r = 1; e.mr += dw + 1; end
            OP_SW:    begin e.cycles = 4 + fw + dw; e.mw = dw + 1; end
            OP_BEQ:   begin e.cycles = 3 + fw; e.pcc = 1; end
            OP_JMP:   begin e.cycles = 3 + fw; e.pw = 2; e.last_src = 2; end
            default:  begin e.cycles = 2 + fw; e.done = 0; e.ill = 1; end
        endcase
        return e;
    endfunction

    // Stimulus half: stall and opcode (opcode only meaningful in the decode cycle).
    always @(posedge clk) begin
        #2;
        if (run_en) begin
            dec_now = dec_next;
`ifdef MULTICYCLE_CU_STALL_EN
            st = ($urandom_range(0, 5) == 0);
            bus.stall = st;
`else
            st = 1'b0;
`endif
            bus.opcode = dec_now ? OPW'(cur_op) : OPW'($urandom);
        end
    end

    // Memory responder: each access waits the number of cycles queued for it.
    always @(posedge clk) begin
        bit req, rdy, fetched;
        #3;
        if (run_en) begin
            fetched = 1'b0;
            req = bus.mem_read | bus.mem_write;
            if (req) begin
                if (!in_access) begin
                    in_access = 1'b1;
                    wait_left = (latq.size() > 0) ? latq.pop_front() : 0;
                end
                rdy = (wait_left == 0);
                if (wait_left > 0) wait_left--;
                if (rdy) begin
                    in_access = 1'b0;
                    fetched = bus.mem_read && !bus.i_or_d;
                end
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            bus.mem_ready = rdy;
            dec_next = fetched || (dec_now && st);
            if (fetched) cur_op = (opq.size() > 0) ? opq.pop_front() : OP_JMP;
        end
    end

    // Monitor: accumulate per instruction, compare against the scoreboard at retirement.
    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (run_en) begin
            cyc++;
`ifdef MULTICYCLE_CU_STALL_EN
            if (bus.stall) begin
                nst++;
                check("stall_mask", int'({bus.reg_write, bus.mem_write, bus.pc_write,
                      bus.pc_write_cond, bus.ir_write, bus.instr_done, bus.illegal,
                      bus.mem_read}), 0);
            end
`endif
            a_mr  += int'(bus.mem_read);
            a_mw  += int'(bus.mem_write);
            a_rw  += int'(bus.reg_write);
            a_pw  += int'(bus.pc_write);
            a_pcc += int'(bus.pc_write_cond);
            a_irw += int'(bus.ir_write);
            a_done += int'(bus.instr_done);
            a_ill += int'(bus.illegal);
            if (bus.reg_write) begin a_rdst = int'(bus.reg_dest); a_m2r = int'(bus.mem_to_reg); end
            if (bus.pc_write) a_src = int'(bus.pc_src);
            if (bus.pc_write_cond) begin a_pcc_src = int'(bus.pc_src); a_pcc_op = int'(bus.alu_op); end
            check("rd_wr_exclusive", int'(bus.mem_read & bus.mem_write), 0);
            check("regwr_memwr_exclusive", int'(bus.reg_write & bus.mem_write), 0);
            if ((bus.instr_done || bus.illegal) && expq.size() > 0) begin
                e = expq.pop_front();
                t = $sformatf("i%0d_op%0d", retired, e.op);
                check({t, "_cycles"}, cyc - nst, e.cycles);
                check({t, "_mem_read_cycles"}, a_mr, e.mr);
                check({t, "_mem_write_cycles"}, a_mw, e.mw);
                check({t, "_reg_write"}, a_rw, e.rw);
                check({t, "_pc_write"}, a_pw, e.pw);
                check({t, "_pc_write_cond"}, a_pcc, e.pcc);
                check({t, "_ir_write"}, a_irw, e.irw);
                check({t, "_instr_done"}, a_done, e.done);
                check({t, "_illegal"}, a_ill, e.ill);
                check({t, "_pc_src"}, a_src, e.last_src);
                if (e.rw == 1) begin
                    check({t, "_reg_dest"}, a_rdst, e.rdst);
                    check({t, "_mem_to_reg"}, a_m2r, e.m2r);
                end
                if (e.pcc == 1) begin
                    check({t, "_beq_pc_src"}, a_pcc_src, 1);
                    check({t, "_beq_alu_op"}, a_pcc_op, 1);
                end
                retired++;
            end
            if (bus.instr_done || bus.illegal) begin
                cyc = 0; nst = 0; a_mr = 0; a_mw = 0; a_rw = 0; a_pw = 0; a_pcc = 0;
                a_irw = 0; a_done = 0; a_ill = 0; a_src = 0;
            end
        end
    end

    initial begin
        bit found;
        int fw, dw, op;
        bus.opcode = '0;
        bus.mem_ready = 1'b0;
`ifdef MULTICYCLE_CU_STALL_EN
        bus.stall = 1'b0;
`endif
        // Directed: outputs during reset, fetch after release, abort mid-MEMRD.
        repeat (2) @(negedge clk);
        check("reset_outputs", int'(outs()), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode = OPW'(OP_LW);
        @(negedge clk);
        check("fetch_mem_read", int'(bus.mem_read), 1);
        check("fetch_i_or_d", int'(bus.i_or_d), 0);
        check("fetch_ir_write", int'(bus.ir_write), 1);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            found = bus.mem_read && bus.i_or_d;
        end
        check("reach_memrd", int'(found), 1);
        #1 rst = 1'b1;
        #1 check("reset_mid_memrd", int'(outs()), 0);
        @(posedge clk); #1;
        check("reset_held", int'(outs()), 0);
        rst = 1'b0;
        @(negedge clk);
        check("refetch_mem_read", int'(bus.mem_read), 1);
        check("refetch_i_or_d", int'(bus.i_or_d), 0);
        check("refetch_reg_write", int'(bus.reg_write), 0);

        // Random stream: expectations queued as the stimulus is generated.
        for (int i = 0; i < N_INSTR; i++) begin
            op = int'($urandom_range(0, 7));
            fw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            dw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            opq.push_back(op);
            latq.push_back(fw);
            if (op == OP_LW || op == OP_SW) latq.push_back(dw);
            expq.push_back(model(op, fw, dw));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_en = 1'b1;
        for (int c = 0; c < 40000 && retired < N_INSTR; c++) @(negedge clk);
        check("all_retired", retired, N_INSTR);
        run_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
